channel_in_tile_accumulator: RTL

Temporal partial-sum accumulator that consumes the per-picture reduced sums leaving the channel-in adder tree. When a layer's input channels exceed COMPUTE_CHANNEL_IN_NUM, the tree emits one partial sum per channel-in tile for the same output pixel. This block adds those tiles over consecutive beats, saturates to the accumulator width and hands one finished sum vector per pixel downstream under a valid/ready handshake. It sits between the channel-in accumulation stage and the bias/quantisation stage.

---
 rtl/channel_in_tile_accumulator_pkg.sv | 14 +
 rtl/channel_in_tile_accumulator_lane.sv | 55 +++++
 rtl/channel_in_tile_accumulator.sv | 90 +++++++++
 3 files changed

// File: rtl/channel_in_tile_accumulator_pkg.sv
// Shared defaults and FSM encoding for the channel-in tile accumulator.
package channel_in_tile_accumulator_pkg;

    localparam int unsigned DefLaneNum      = 4;
    localparam int unsigned DefInWidth      = 16;
    localparam int unsigned DefGuardBits    = 8;
    localparam int unsigned DefTileCntWidth = 12;

    typedef enum logic {
        StIdle,
        StRun
    } acc_state_e;

endpackage

// File: rtl/channel_in_tile_accumulator_lane.sv
// One lane: sign-extend, saturating add, accumulator register and sticky saturation flag.
// o_sum is the combinational result of the beat currently presented.
module tile_acc_lane #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned GUARD_BITS = 8,
    localparam int unsigned ACC_WIDTH = IN_WIDTH + GUARD_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_first,
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_sat
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sat;
    logic [ACC_WIDTH-1:0] w_in_sext;
    logic [ACC_WIDTH:0]   w_wide;
    logic                 w_ovf;
    logic                 w_clamp;

    assign w_in_sext = {{GUARD_BITS{i_data[IN_WIDTH-1]}}, i_data};
    // One extra bit so the true sum is exact and overflow shows as a sign disagreement.
    assign w_wide    = {r_acc[ACC_WIDTH-1], r_acc} + {w_in_sext[ACC_WIDTH-1], w_in_sext};
    assign w_ovf     = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
    assign w_clamp   = !i_first && w_ovf;

    always_comb begin
        o_sum = w_wide[ACC_WIDTH-1:0];
        if (i_first) begin
            o_sum = w_in_sext;
        end else if (w_ovf) begin
            o_sum = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_load) begin
            r_acc <= o_sum;
            if (w_clamp) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_sat = r_sat;

endmodule

// File: rtl/channel_in_tile_accumulator.sv
// Temporal accumulator of channel-in tile partial sums; emits one saturated sum vector
// per output pixel under valid/ready.
module channel_in_tile_accumulator
    import channel_in_tile_accumulator_pkg::*;
#(
    parameter int unsigned LANE_NUM       = DefLaneNum,
    parameter int unsigned IN_WIDTH       = DefInWidth,
    parameter int unsigned GUARD_BITS     = DefGuardBits,
    parameter int unsigned TILE_CNT_WIDTH = DefTileCntWidth,
    localparam int unsigned ACC_WIDTH     = IN_WIDTH + GUARD_BITS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [TILE_CNT_WIDTH-1:0]     i_tile_num,
    input  logic [LANE_NUM*IN_WIDTH-1:0]  i_data_in,
    input  logic                          i_data_in_valid,
    output logic                          o_data_in_ready,
    output logic [LANE_NUM*ACC_WIDTH-1:0] o_data_out,
    output logic                          o_data_out_valid,
    input  logic                          i_data_out_ready,
    output logic                          o_overflow
);

    acc_state_e                    r_state;
    logic [TILE_CNT_WIDTH-1:0]     r_tcnt;
    logic [TILE_CNT_WIDTH-1:0]     r_tlast;
    logic [LANE_NUM*ACC_WIDTH-1:0] r_out;
    logic                          r_out_valid;

    logic                          w_last;
    logic                          w_ready;
    logic                          w_xfer;
    logic [TILE_CNT_WIDTH-1:0]     w_tlast_in;
    logic [LANE_NUM*ACC_WIDTH-1:0] w_sum;
    logic [LANE_NUM-1:0]           w_lane_sat;

    assign w_last     = (r_tcnt == r_tlast);
    // Only the final tile has to wait for a stalled output; earlier tiles keep flowing.
    assign w_ready    = (r_state == StRun) && !(r_out_valid && !i_data_out_ready && w_last);
    assign w_xfer     = i_data_in_valid && w_ready && !i_start;
    assign w_tlast_in = (i_tile_num == '0) ? '0 : i_tile_num - TILE_CNT_WIDTH'(1);

    for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
        tile_acc_lane #(
            .IN_WIDTH   (IN_WIDTH),
            .GUARD_BITS (GUARD_BITS)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clear (i_start),
            .i_load  (w_xfer),
            .i_first (r_tcnt == '0),
            .i_data  (i_data_in[g*IN_WIDTH +: IN_WIDTH]),
            .o_sum   (w_sum[g*ACC_WIDTH +: ACC_WIDTH]),
            .o_sat   (w_lane_sat[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_tcnt      <= '0;
            r_tlast     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (i_start) begin
            r_state     <= StRun;
            r_tcnt      <= '0;
            r_tlast     <= w_tlast_in;
            r_out_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_tcnt <= w_last ? '0 : r_tcnt + TILE_CNT_WIDTH'(1);
            end
            if (w_xfer && w_last) begin
                r_out       <= w_sum;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_data_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_data_in_ready  = w_ready;
    assign o_data_out       = r_out;
    assign o_data_out_valid = r_out_valid;
    assign o_overflow       = |w_lane_sat;

endmodule
